// File: rtl/usr_serial_ctrl.sv
// usr_serial_ctrl
//   Upstream sequencer for a universal shift register
//   (mode 00 hold, 01 shift right, 10 shift left, 11 parallel load).
//   Accepts a parallel word over valid/ready, loads it into the register,
//   then shifts it out one bit slot per cycle, turning the register into a
//   framed PISO transmitter.
//
// Parameters:
//   WIDTH     - word width, must match the shift register (>= 2)
//   LSB_FIRST - 0: MSB first, shift left, fill through sl_in
//               1: LSB first, shift right, fill through sr_in
//
// Optional build macro:
//   USR_SERIAL_PARITY_EN - appends an even-parity slot to every frame.
//                          The parity bit is shifted in on the first shift,
//                          so it reaches the serial output in the final slot.
//
// Ports:
//   clk        - rising-edge clock
//   rst        - synchronous active-high reset
//   in_data    - word to transmit, captured on in_valid & in_ready
//   in_valid   - upstream word available
//   in_ready   - block can accept a word this cycle (0 while rst is high)
//   stall      - downstream not ready; freezes the current bit slot
//   mode       - shift register mode
//   p_load     - shift register parallel input
//   sl_in      - shift register left-shift fill input
//   sr_in      - shift register right-shift fill input
//   bit_valid  - serial bit at the register output is consumed this cycle
//   frame_done - pulse on the last consumed slot of a frame
//   busy       - frame in progress (LOAD or SHIFT)

module usr_serial_ctrl #(
   parameter int WIDTH     = 4,
   parameter bit LSB_FIRST = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             stall,
   output logic [1:0]       mode,
   output logic [WIDTH-1:0] p_load,
   output logic             sl_in,
   output logic             sr_in,
   output logic             bit_valid,
   output logic             frame_done,
   output logic             busy
);

`ifdef USR_SERIAL_PARITY_EN
   localparam int N = WIDTH + 1;
`else
   localparam int N = WIDTH;
`endif

   localparam int            CW         = $clog2(WIDTH + 2);
   localparam logic [CW-1:0] LAST       = CW'(N - 1);
   localparam logic [1:0]    MODE_HOLD  = 2'b00;
   localparam logic [1:0]    MODE_LOAD  = 2'b11;
   localparam logic [1:0]    MODE_SHIFT = LSB_FIRST ? 2'b01 : 2'b10;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      SHIFT
   } state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic             fill;

`ifdef USR_SERIAL_PARITY_EN
   // Parity rides in on the first shift; all later fills are zero.
   assign fill = (cnt_q == '0) ? ^data_q : 1'b0;
`else
   assign fill = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      data_d     = data_q;
      mode       = MODE_HOLD;
      p_load     = '0;
      sl_in      = 1'b0;
      sr_in      = 1'b0;
      bit_valid  = 1'b0;
      frame_done = 1'b0;
      busy       = 1'b0;
      in_ready   = 1'b0;

      unique case (state_q)
         IDLE: begin
            in_ready = ~rst;
            if (in_valid) begin
               data_d  = in_data;
               state_d = LOAD;
            end
         end

         LOAD: begin
            mode    = MODE_LOAD;
            p_load  = data_q;
            busy    = 1'b1;
            cnt_d   = '0;
            state_d = SHIFT;
         end

         SHIFT: begin
            busy = 1'b1;
            // Fill depends only on registered state; a stall holds the
            // register through mode, so the fill value is harmless then.
            if (cnt_q != LAST) begin
               if (LSB_FIRST) sr_in = fill;
               else           sl_in = fill;
            end
            if (!stall) begin
               bit_valid = 1'b1;
               if (cnt_q == LAST) begin
                  frame_done = 1'b1;
                  in_ready   = ~rst;
                  if (in_valid) begin
                     data_d  = in_data;
                     state_d = LOAD;
                  end else begin
                     state_d = IDLE;
                  end
               end else begin
                  mode  = MODE_SHIFT;
                  cnt_d = cnt_q + CW'(1);
               end
            end
         end

         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_usr_serial_ctrl.sv
module tb_usr_serial_ctrl;

`ifdef USR_SERIAL_PARITY_EN
   localparam int NS  = 5;
   localparam bit PAR = 1'b1;
`else
   localparam int NS  = 4;
   localparam bit PAR = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] in_data;
   logic       in_valid;
   logic       stall;

   logic       in_ready0, sl_in0, sr_in0, bit_valid0, frame_done0, busy0;
   logic [1:0] mode0;
   logic [3:0] p_load0;
   logic       in_ready1, sl_in1, sr_in1, bit_valid1, frame_done1, busy1;
   logic [1:0] mode1;
   logic [3:0] p_load1;

   logic [3:0] q0 = '0;
   logic [3:0] q1 = '0;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   usr_serial_ctrl #(.WIDTH(4), .LSB_FIRST(1'b0)) dut0 (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready0), .stall(stall), .mode(mode0), .p_load(p_load0),
      .sl_in(sl_in0), .sr_in(sr_in0), .bit_valid(bit_valid0),
      .frame_done(frame_done0), .busy(busy0));

   usr_serial_ctrl #(.WIDTH(4), .LSB_FIRST(1'b1)) dut1 (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready1), .stall(stall), .mode(mode1), .p_load(p_load1),
      .sl_in(sl_in1), .sr_in(sr_in1), .bit_valid(bit_valid1),
      .frame_done(frame_done1), .busy(busy1));

   // Behavioural 4-bit universal shift registers driven by each controller.
   always @(posedge clk) begin
      case (mode0)
         2'b01: q0 <= {sr_in0, q0[3:1]};
         2'b10: q0 <= {q0[2:0], sl_in0};
         2'b11: q0 <= p_load0;
         default: q0 <= q0;
      endcase
      case (mode1)
         2'b01: q1 <= {sr_in1, q1[3:1]};
         2'b10: q1 <= {q1[2:0], sl_in1};
         2'b11: q1 <= p_load1;
         default: q1 <= q1;
      endcase
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; in_data = 4'b0000; stall = 1'b0;
      tick(); tick(); in_valid = 1'b1; #1;
      checks++; if (in_ready0 !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b expected 0", in_ready0); end
      checks++; if (mode0 !== 2'b00) begin errors++; $display("FAIL rst_mode: got %b expected 00", mode0); end
      checks++; if (p_load0 !== 4'b0000) begin errors++; $display("FAIL rst_p_load: got %b expected 0000", p_load0); end
      checks++; if ({sl_in0, sr_in0} !== 2'b00) begin errors++; $display("FAIL rst_fill: got %b expected 00", {sl_in0, sr_in0}); end
      checks++; if ({bit_valid0, frame_done0, busy0} !== 3'b000) begin errors++; $display("FAIL rst_flags: got %b expected 000", {bit_valid0, frame_done0, busy0}); end
      checks++; if (in_ready1 !== 1'b0) begin errors++; $display("FAIL rst_in_ready1: got %b expected 0", in_ready1); end
      tick();
      in_valid = 1'b0; rst = 1'b0; #1;
      checks++; if (in_ready0 !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %b expected 1", in_ready0); end
      checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL rst_release_busy: got %b expected 0", busy0); end
      tick();
   endtask

   task automatic test_msb_frame();
      logic [4:0] exp;
      exp = 5'b10100;
      in_data = 4'b1010; in_valid = 1'b1; #1;
      checks++; if (in_ready0 !== 1'b1) begin errors++; $display("FAIL msb_idle_ready: got %b expected 1", in_ready0); end
      tick();
      in_valid = 1'b0; in_data = 4'b1111; #1;
      checks++; if (mode0 !== 2'b11) begin errors++; $display("FAIL msb_load_mode: got %b expected 11", mode0); end
      checks++; if (p_load0 !== 4'b1010) begin errors++; $display("FAIL msb_load_data: got %b expected 1010", p_load0); end
      checks++; if ({busy0, in_ready0, bit_valid0} !== 3'b100) begin errors++; $display("FAIL msb_load_flags: got %b expected 100", {busy0, in_ready0, bit_valid0}); end
      tick();
      for (int s = 0; s < NS; s++) begin
         #1;
         checks++; if (bit_valid0 !== 1'b1) begin errors++; $display("FAIL msb_bv slot%0d: got %b expected 1", s, bit_valid0); end
         checks++; if (mode0 !== ((s == NS-1) ? 2'b00 : 2'b10)) begin errors++; $display("FAIL msb_mode slot%0d: got %b", s, mode0); end
         checks++; if (frame_done0 !== (s == NS-1)) begin errors++; $display("FAIL msb_fd slot%0d: got %b", s, frame_done0); end
         checks++; if (q0[3] !== exp[4-s]) begin errors++; $display("FAIL msb_serial slot%0d: got %b expected %b", s, q0[3], exp[4-s]); end
         checks++; if ({sl_in0, sr_in0} !== 2'b00) begin errors++; $display("FAIL msb_fill slot%0d: got %b expected 00", s, {sl_in0, sr_in0}); end
         tick();
      end
      #1;
      checks++; if ({mode0, busy0, in_ready0} !== 4'b0001) begin errors++; $display("FAIL msb_back_idle: got %b expected 0001", {mode0, busy0, in_ready0}); end
      tick();
   endtask

   task automatic test_lsb_frame();
      logic [4:0] exp;
      exp = 5'b10111;
      in_data = 4'b1101; in_valid = 1'b1;
      tick();
      in_valid = 1'b0; #1;
      checks++; if ({mode1, p_load1} !== 6'b11_1101) begin errors++; $display("FAIL lsb_load: got %b expected 111101", {mode1, p_load1}); end
      tick();
      for (int s = 0; s < NS; s++) begin
         #1;
         checks++; if (mode1 !== ((s == NS-1) ? 2'b00 : 2'b01)) begin errors++; $display("FAIL lsb_mode slot%0d: got %b", s, mode1); end
         checks++; if (q1[0] !== exp[4-s]) begin errors++; $display("FAIL lsb_serial slot%0d: got %b expected %b", s, q1[0], exp[4-s]); end
         checks++; if (sl_in1 !== 1'b0) begin errors++; $display("FAIL lsb_sl_in slot%0d: got %b expected 0", s, sl_in1); end
         checks++; if (sr_in1 !== ((s == 0) ? PAR : 1'b0)) begin errors++; $display("FAIL lsb_sr_in slot%0d: got %b", s, sr_in1); end
         checks++; if ({bit_valid1, frame_done1} !== {1'b1, s == NS-1}) begin errors++; $display("FAIL lsb_flags slot%0d: got %b", s, {bit_valid1, frame_done1}); end
         tick();
      end
      #1;
      checks++; if ({mode1, busy1} !== 3'b000) begin errors++; $display("FAIL lsb_back_idle: got %b expected 000", {mode1, busy1}); end
      tick();
   endtask

   task automatic test_back_to_back();
      logic [9:0] exp;
      exp = 10'b00110_11000;
      in_data = 4'b0011; in_valid = 1'b1;
      tick();
      in_data = 4'b1100; #1;
      checks++; if ({mode0, p_load0} !== 6'b11_0011) begin errors++; $display("FAIL b2b_load1: got %b expected 110011", {mode0, p_load0}); end
      tick();
      for (int f = 0; f < 2; f++) begin
         for (int s = 0; s < NS; s++) begin
            #1;
            checks++; if (q0[3] !== exp[9-5*f-s]) begin errors++; $display("FAIL b2b_serial f%0d slot%0d: got %b expected %b", f, s, q0[3], exp[9-5*f-s]); end
            checks++; if ({bit_valid0, frame_done0} !== {1'b1, s == NS-1}) begin errors++; $display("FAIL b2b_flags f%0d slot%0d: got %b", f, s, {bit_valid0, frame_done0}); end
            checks++; if (in_ready0 !== (s == NS-1)) begin errors++; $display("FAIL b2b_ready f%0d slot%0d: got %b", f, s, in_ready0); end
            tick();
         end
         if (f == 0) begin
            in_valid = 1'b0; #1;
            checks++; if ({mode0, p_load0} !== 6'b11_1100) begin errors++; $display("FAIL b2b_load2: got %b expected 111100", {mode0, p_load0}); end
            tick();
         end
      end
      #1;
      checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL b2b_idle: got %b expected 0", busy0); end
      tick();
   endtask

   task automatic test_stall();
      logic [4:0] exp;
      exp = 5'b10100;
      in_data = 4'b1010; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      for (int s = 0; s < NS; s++) begin
         if (s == 2) begin
            for (int k = 0; k < 3; k++) begin
               stall = 1'b1; #1;
               checks++; if ({mode0, bit_valid0, frame_done0, in_ready0, busy0} !== 6'b000001) begin errors++; $display("FAIL stall_out c%0d: got %b expected 000001", k, {mode0, bit_valid0, frame_done0, in_ready0, busy0}); end
               tick();
            end
            stall = 1'b0;
         end
         #1;
         checks++; if (q0[3] !== exp[4-s]) begin errors++; $display("FAIL stall_serial slot%0d: got %b expected %b", s, q0[3], exp[4-s]); end
         checks++; if ({bit_valid0, frame_done0} !== {1'b1, s == NS-1}) begin errors++; $display("FAIL stall_flags slot%0d: got %b", s, {bit_valid0, frame_done0}); end
         tick();
      end
      #1;
      checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL stall_idle: got %b expected 0", busy0); end
      tick();
   endtask

   task automatic test_reset_mid_frame();
      logic [4:0] exp;
      exp = 5'b01100;
      in_data = 4'b1010; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick(); tick(); tick();
      rst = 1'b1;
      tick();
      rst = 1'b0; #1;
      checks++; if ({mode0, p_load0, sl_in0, sr_in0} !== 8'h00) begin errors++; $display("FAIL midrst_out: got %b expected 0", {mode0, p_load0, sl_in0, sr_in0}); end
      checks++; if ({bit_valid0, frame_done0, busy0, in_ready0} !== 4'b0001) begin errors++; $display("FAIL midrst_flags: got %b expected 0001", {bit_valid0, frame_done0, busy0, in_ready0}); end
      in_data = 4'b0110; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      for (int s = 0; s < NS; s++) begin
         #1;
         checks++; if (q0[3] !== exp[4-s]) begin errors++; $display("FAIL midrst_serial slot%0d: got %b expected %b", s, q0[3], exp[4-s]); end
         checks++; if (frame_done0 !== (s == NS-1)) begin errors++; $display("FAIL midrst_fd slot%0d: got %b", s, frame_done0); end
         tick();
      end
   endtask

   task automatic test_parity();
      logic [4:0] exp;
      exp = 5'b10111;
      in_data = 4'b1011; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      for (int s = 0; s < NS; s++) begin
         #1;
         checks++; if (sl_in0 !== ((s == 0) ? PAR : 1'b0)) begin errors++; $display("FAIL par_sl_in slot%0d: got %b", s, sl_in0); end
         checks++; if (q0[3] !== exp[4-s]) begin errors++; $display("FAIL par_serial slot%0d: got %b expected %b", s, q0[3], exp[4-s]); end
         checks++; if ({bit_valid0, frame_done0} !== {1'b1, s == NS-1}) begin errors++; $display("FAIL par_flags slot%0d: got %b", s, {bit_valid0, frame_done0}); end
         tick();
      end
      #1;
      checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL par_idle: got %b expected 0", busy0); end
   endtask

   initial begin
      #1;
      test_reset();
      test_msb_frame();
      test_lsb_frame();
      test_back_to_back();
      test_stall();
      test_reset_mid_frame();
      test_parity();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/usr_serial_ctrl.md
Name: usr_serial_ctrl

Overview:
- Upstream sequencer for the 4-bit universal shift register (mode codes 00 hold, 01 shift right, 10 shift left, 11 parallel load).
- Accepts parallel words over a valid/ready handshake.
- Drives the register's mode, parallel-load and serial-fill inputs so it emits each word as a serial bitstream, one bit slot per cycle.
- Flags each valid serial slot, frame completion, and downstream stalls; turns the register into a framed PISO transmitter.

Parameters:
- WIDTH, 4: data word width; must match the shift register width; legal range >= 2.
- LSB_FIRST, 0: 0 = MSB first, shift left, serial bit is P_out[WIDTH-1], fill via SLin. 1 = LSB first, shift right, serial bit is P_out[0], fill via SRin.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_data  input  WIDTH  word to transmit; sampled on handshake.
- in_valid  input  1  upstream word available.
- in_ready  output  1  block can accept a word this cycle.
- stall  input  1  downstream not ready; freezes the current bit slot.
- mode  output  2  to shift register mode.
- p_load  output  WIDTH  to shift register P_in.
- sl_in  output  1  to shift register SLin.
- sr_in  output  1  to shift register SRin.
- bit_valid  output  1  serial bit at register output is valid and consumed this cycle.
- frame_done  output  1  one-cycle pulse coincident with the last consumed slot of a frame.
- busy  output  1  frame in progress (LOAD or SHIFT).

Behaviour:
- States: IDLE, LOAD, SHIFT. Bit-slot counter cnt is $clog2(WIDTH+2) bits. Captured word register data_q.
- Reset (rst=1 at an edge, any state, including mid-frame):
  - Next state IDLE; cnt=0; data_q=0.
  - Outputs: mode=00, p_load=0, sl_in=0, sr_in=0, bit_valid=0, frame_done=0, busy=0.
  - in_ready is forced 0 while rst is high.
- IDLE:
  - mode=00, in_ready=1, busy=0.
  - On in_valid&in_ready: data_q<=in_data; go to LOAD.
- LOAD (exactly 1 cycle):
  - mode=11, p_load=data_q, busy=1, in_ready=0, bit_valid=0.
  - The register loads at the end of this cycle. cnt<=0; go to SHIFT.
- SHIFT:
  - busy=1. Slot count N = WIDTH, or WIDTH+1 with the optional feature.
  - stall=0, cnt<N-1:
    - bit_valid=1.
    - mode=10 (LSB_FIRST=0) or 01 (LSB_FIRST=1).
    - Active fill output = fill bit; the inactive fill output = 0.
    - cnt<=cnt+1.
  - stall=0, cnt==N-1 (last slot):
    - bit_valid=1, frame_done=1, mode=00, in_ready=1.
    - If in_valid: capture and go to LOAD (back-to-back frames, WIDTH+1 or N+1 cycles per word); else go to IDLE.
  - stall=1 (any slot): mode=00, bit_valid=0, frame_done=0, in_ready=0; cnt and state held. The register holds, so the same bit is presented next cycle.
- Timing and paths:
  - stall and in_valid reach outputs combinationally only via mode/bit_valid/frame_done/in_ready as stated above.
  - All other outputs are functions of registered state.
- Fill bit is 0 on every shift, except as modified by the optional feature.
- Serial order: first slot = data_q[WIDTH-1] (LSB_FIRST=0) or data_q[0] (LSB_FIRST=1), then successive bits.
- in_data changing while not handshaked has no effect.

Optional Feature:
- Macro: USR_SERIAL_PARITY_EN.
- Defined:
  - N = WIDTH+1.
  - On the first shift of a frame, fill bit = ^data_q (even parity); all later fills = 0.
  - The parity bit reaches the serial output position after WIDTH shifts, so it appears in the final slot.
- Undefined: N = WIDTH, and the parity logic is absent.

Test Plan:
- Reset then in_data=1010, in_valid 1 cycle -> in_ready drops; LOAD cycle mode=11, p_load=1010; 4 SHIFT slots with bit_valid=1, modes 10,10,10,00; frame_done on 4th slot; serial bits observed 1,0,1,0; return to IDLE with mode=00.
- LSB_FIRST=1, in_data=1101 -> modes 01,01,01,00; sr_in=0, sl_in=0; serial bits 1,0,1,1.
- Back-to-back: in_valid held high with 0011 then 1100 -> second LOAD immediately after the first frame_done; 5-cycle period per word; serial 0,0,1,1,1,1,0,0.
- stall=1 for 3 cycles during slot 2 of 1010 -> mode=00, bit_valid=0 for those cycles; the bit is not repeated or lost; frame_done is delayed 3 cycles.
- rst=1 during slot 2 -> next cycle IDLE, all outputs 0, busy=0; a new word 0110 after release transmits cleanly as 0,1,1,0.
- USR_SERIAL_PARITY_EN, in_data=1011 -> first shift sl_in=1; 5 slots; serial 1,0,1,1,1; frame_done on 5th. in_data=1010 -> parity slot 0.
